// File: rtl/NanoCore_pkg.sv
// Shared NanoCore types: decoded micro-op control from d2 and register-file sizing.
package NanoCore_pkg;

   localparam int regfile_size   = 32;
   localparam int regindex_bits  = $clog2(regfile_size);

   typedef struct packed {
      logic        is_add;
      logic        is_sub;
      logic        is_sll;
      logic        is_slt;
      logic        is_sltu;
      logic        is_xor;
      logic        is_srl;
      logic        is_sra;
      logic        is_or;
      logic        is_and;
      logic        instr_beq;
      logic        instr_bne;
      logic        instr_blt;
      logic        instr_bge;
      logic        instr_bltu;
      logic        instr_bgeu;
      logic        instr_jalr;
      logic [31:0] decoded_imm;
   } uop_ctl_t;

   function automatic logic uop_is_alu(input uop_ctl_t c);
      return c.is_add | c.is_sub | c.is_sll | c.is_slt | c.is_sltu |
             c.is_xor | c.is_srl | c.is_sra | c.is_or  | c.is_and;
   endfunction

   function automatic logic uop_is_cond_branch(input uop_ctl_t c);
      return c.instr_beq | c.instr_bne | c.instr_blt |
             c.instr_bge | c.instr_bltu | c.instr_bgeu;
   endfunction

endpackage

// File: rtl/n2_exec_unit_alu.sv
// Combinational half of the execute stage: ALU result, branch decision and redirect target.
module n2_exec_unit_alu
   import NanoCore_pkg::*;
(
   input  uop_ctl_t                 uop_ctl,
   input  logic [31:0]              op1,
   input  logic [31:0]              op2,
   input  logic [31:0]              cur_pc,
   input  logic [regindex_bits-1:0] rf_dst,
   output logic [31:0]              alu_rst,
   output logic                     rf_we,
   output logic                     is_branch,
   output logic [31:0]              branch_pc,
   output logic [regindex_bits-1:0] rf_dst_eff
);

   logic [4:0]  shamt;
   logic        eq;
   logic        lt_s;
   logic        lt_u;
   logic        taken;
   logic        is_cond;
   logic [31:0] jalr_sum;

   assign shamt    = op2[4:0];
   assign eq       = (op1 == op2);
   assign lt_s     = ($signed(op1) < $signed(op2));
   assign lt_u     = (op1 < op2);
   assign is_cond  = uop_is_cond_branch(uop_ctl);
   assign jalr_sum = op1 + uop_ctl.decoded_imm;

   always_comb begin
      alu_rst = '0;
      if (uop_ctl.is_add)       alu_rst = op1 + op2;
      else if (uop_ctl.is_sub)  alu_rst = op1 - op2;
      else if (uop_ctl.is_sll)  alu_rst = op1 << shamt;
      else if (uop_ctl.is_slt)  alu_rst = {31'd0, lt_s};
      else if (uop_ctl.is_sltu) alu_rst = {31'd0, lt_u};
      else if (uop_ctl.is_xor)  alu_rst = op1 ^ op2;
      else if (uop_ctl.is_srl)  alu_rst = op1 >> shamt;
      else if (uop_ctl.is_sra)  alu_rst = $unsigned($signed(op1) >>> shamt);
      else if (uop_ctl.is_or)   alu_rst = op1 | op2;
      else if (uop_ctl.is_and)  alu_rst = op1 & op2;
   end

   assign taken = (uop_ctl.instr_beq  &  eq)   |
                  (uop_ctl.instr_bne  & ~eq)   |
                  (uop_ctl.instr_blt  &  lt_s) |
                  (uop_ctl.instr_bge  & ~lt_s) |
                  (uop_ctl.instr_bltu &  lt_u) |
                  (uop_ctl.instr_bgeu & ~lt_u);

   // Conditional branches report rd as x0 because the top writes the link value on redirect.
   assign rf_we      = uop_is_alu(uop_ctl);
   assign is_branch  = taken | uop_ctl.instr_jalr;
   assign branch_pc  = uop_ctl.instr_jalr ? {jalr_sum[31:1], 1'b0}
                                          : cur_pc + uop_ctl.decoded_imm;
   assign rf_dst_eff = is_cond ? '0 : rf_dst;

endmodule

// File: rtl/n2_exec_unit.sv
// Single-cycle integer execute stage: registers the ALU result or branch/JALR redirect one cycle after issue.
module n2_exec_unit
   import NanoCore_pkg::*;
#(
   parameter int TWO_CYCLE_ALU     = 0,
   parameter int TWO_CYCLE_COMPARE = 0
)(
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     to_ex_v_i,
   input  logic [7:0]               uid_d2_i,
   output logic [7:0]               uid_ex_o,
   input  logic [regindex_bits-1:0] rf_dst_idu_i,
   output logic [regindex_bits-1:0] rf_dst_ex_o,
   input  uop_ctl_t                 uop_ctl_i,
   input  logic [31:0]              alu_op1_i,
   input  logic [31:0]              alu_op2_i,
   output logic [31:0]              alu_rst_ex_o,
   output logic                     rf_we_ex_o,
   output logic                     is_branch_ex_o,
   output logic [31:0]              branch_pc_ex_o,
   input  logic [31:0]              cur_pc_d2_i,
   output logic [31:0]              cur_pc_ex_o
);

   // The latency knobs are kept for drop-in compatibility; the stage is always one cycle.
   if (TWO_CYCLE_ALU != 0 || TWO_CYCLE_COMPARE != 0) begin : g_latency_knobs_ignored
   end

   logic [31:0]              alu_rst_c;
   logic                     rf_we_c;
   logic                     is_branch_c;
   logic [31:0]              branch_pc_c;
   logic [regindex_bits-1:0] rf_dst_c;

   n2_exec_unit_alu u_alu (
      .uop_ctl    (uop_ctl_i),
      .op1        (alu_op1_i),
      .op2        (alu_op2_i),
      .cur_pc     (cur_pc_d2_i),
      .rf_dst     (rf_dst_idu_i),
      .alu_rst    (alu_rst_c),
      .rf_we      (rf_we_c),
      .is_branch  (is_branch_c),
      .branch_pc  (branch_pc_c),
      .rf_dst_eff (rf_dst_c)
   );

   // Strobes drop on idle cycles while the data registers keep the last executed micro-op.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         uid_ex_o       <= '0;
         rf_dst_ex_o    <= '0;
         alu_rst_ex_o   <= '0;
         rf_we_ex_o     <= 1'b0;
         is_branch_ex_o <= 1'b0;
         branch_pc_ex_o <= '0;
         cur_pc_ex_o    <= '0;
      end else if (to_ex_v_i) begin
         uid_ex_o       <= uid_d2_i;
         rf_dst_ex_o    <= rf_dst_c;
         alu_rst_ex_o   <= alu_rst_c;
         rf_we_ex_o     <= rf_we_c;
         is_branch_ex_o <= is_branch_c;
         branch_pc_ex_o <= branch_pc_c;
         cur_pc_ex_o    <= cur_pc_d2_i;
      end else begin
         rf_we_ex_o     <= 1'b0;
         is_branch_ex_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_n2_exec_unit.sv
// Scoreboard bench for n2_exec_unit: directed cases plus random micro-ops against a behavioural model.
module tb_n2_exec_unit;
   import NanoCore_pkg::*;

   typedef enum int {
      K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
      K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU, K_JALR, K_NONE
   } kind_t;

   typedef struct {
      string       name;
      logic [7:0]  uid;
      logic [4:0]  dst;
      logic [31:0] pc;
      logic [31:0] res;
      logic [31:0] tgt;
      logic        we;
      logic        br;
      logic        res_known;
      logic        tgt_known;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        to_ex_v_i;
   logic [7:0]  uid_d2_i;
   logic [7:0]  uid_ex_o;
   logic [4:0]  rf_dst_idu_i;
   logic [4:0]  rf_dst_ex_o;
   uop_ctl_t    uop_ctl_i;
   logic [31:0] alu_op1_i;
   logic [31:0] alu_op2_i;
   logic [31:0] alu_rst_ex_o;
   logic        rf_we_ex_o;
   logic        is_branch_ex_o;
   logic [31:0] branch_pc_ex_o;
   logic [31:0] cur_pc_d2_i;
   logic [31:0] cur_pc_ex_o;

   int   assertCount = 0;
   int   failCount   = 0;
   exp_t sb[$];
   exp_t m;

   n2_exec_unit dut (
      .clk            (clk),
      .resetn         (resetn),
      .to_ex_v_i      (to_ex_v_i),
      .uid_d2_i       (uid_d2_i),
      .uid_ex_o       (uid_ex_o),
      .rf_dst_idu_i   (rf_dst_idu_i),
      .rf_dst_ex_o    (rf_dst_ex_o),
      .uop_ctl_i      (uop_ctl_i),
      .alu_op1_i      (alu_op1_i),
      .alu_op2_i      (alu_op2_i),
      .alu_rst_ex_o   (alu_rst_ex_o),
      .rf_we_ex_o     (rf_we_ex_o),
      .is_branch_ex_o (is_branch_ex_o),
      .branch_pc_ex_o (branch_pc_ex_o),
      .cur_pc_d2_i    (cur_pc_d2_i),
      .cur_pc_ex_o    (cur_pc_ex_o)
   );

   always #5 clk = ~clk;

   function automatic uop_ctl_t makeCtl(input kind_t k, input logic [31:0] imm);
      uop_ctl_t c;
      c = '0;
      c.decoded_imm = imm;
      case (k)
         K_ADD:  c.is_add     = 1'b1;
         K_SUB:  c.is_sub     = 1'b1;
         K_SLL:  c.is_sll     = 1'b1;
         K_SLT:  c.is_slt     = 1'b1;
         K_SLTU: c.is_sltu    = 1'b1;
         K_XOR:  c.is_xor     = 1'b1;
         K_SRL:  c.is_srl     = 1'b1;
         K_SRA:  c.is_sra     = 1'b1;
         K_OR:   c.is_or      = 1'b1;
         K_AND:  c.is_and     = 1'b1;
         K_BEQ:  c.instr_beq  = 1'b1;
         K_BNE:  c.instr_bne  = 1'b1;
         K_BLT:  c.instr_blt  = 1'b1;
         K_BGE:  c.instr_bge  = 1'b1;
         K_BLTU: c.instr_bltu = 1'b1;
         K_BGEU: c.instr_bgeu = 1'b1;
         K_JALR: c.instr_jalr = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   // Reference arithmetic in terms of integer semantics, independent of the RTL structure.
   function automatic logic [31:0] refAlu(input kind_t k, input logic [31:0] a, input logic [31:0] b);
      int unsigned sh;
      longint      sa;
      longint      sb2;
      sh  = b % 32;
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      case (k)
         K_ADD:  return a + b;
         K_SUB:  return a - b;
         K_SLL:  return a << sh;
         K_SLT:  return (sa < sb2) ? 32'd1 : 32'd0;
         K_SLTU: return (a < b) ? 32'd1 : 32'd0;
         K_XOR:  return a ^ b;
         K_SRL:  return a >> sh;
         K_SRA:  return 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
         K_OR:   return a | b;
         K_AND:  return a & b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic refTaken(input kind_t k, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb2;
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      case (k)
         K_BEQ:  return a == b;
         K_BNE:  return a != b;
         K_BLT:  return sa < sb2;
         K_BGE:  return sa >= sb2;
         K_BLTU: return a < b;
         K_BGEU: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic applyStimulus(input bit rstn, input bit v, input kind_t k,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic [4:0] rd, input logic [7:0] uid);
      logic [31:0] sum;
      @(negedge clk);
      resetn       = rstn;
      to_ex_v_i    = v;
      uop_ctl_i    = makeCtl(k, imm);
      alu_op1_i    = a;
      alu_op2_i    = b;
      cur_pc_d2_i  = pc;
      rf_dst_idu_i = rd;
      uid_d2_i     = uid;
      if (!rstn) begin
         m = '{name:"reset", uid:0, dst:0, pc:0, res:0, tgt:0, we:0, br:0, res_known:1, tgt_known:1};
      end else if (!v) begin
         m.name = "idle";
         m.we   = 1'b0;
         m.br   = 1'b0;
      end else begin
         m.name = k.name();
         m.uid  = uid;
         m.pc   = pc;
         m.dst  = rd;
         m.we   = 1'b0;
         m.br   = 1'b0;
         m.res_known = 1'b0;
         m.tgt_known = 1'b0;
         if (k <= K_AND) begin
            m.res = refAlu(k, a, b);
            m.we  = 1'b1;
            m.res_known = 1'b1;
         end else if (k <= K_BGEU) begin
            m.dst = 5'd0;
            m.br  = refTaken(k, a, b);
            if (m.br) begin
               m.tgt = pc + imm;
               m.tgt_known = 1'b1;
            end
         end else if (k == K_JALR) begin
            sum   = a + imm;
            m.br  = 1'b1;
            m.tgt = sum & 32'hFFFF_FFFE;
            m.tgt_known = 1'b1;
         end
      end
      sb.push_back(m);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      assertCount++;
      if (act !== req) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, req);
      end
   endtask

   // Monitor: one scoreboard entry per clock, compared just after the edge that produced it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({e.name, ".uid"},    {24'd0, uid_ex_o},       {24'd0, e.uid});
            checkOutput({e.name, ".dst"},    {27'd0, rf_dst_ex_o},    {27'd0, e.dst});
            checkOutput({e.name, ".pc"},     cur_pc_ex_o,             e.pc);
            checkOutput({e.name, ".we"},     {31'd0, rf_we_ex_o},     {31'd0, e.we});
            checkOutput({e.name, ".br"},     {31'd0, is_branch_ex_o}, {31'd0, e.br});
            if (e.res_known) checkOutput({e.name, ".res"}, alu_rst_ex_o,   e.res);
            if (e.tgt_known) checkOutput({e.name, ".tgt"}, branch_pc_ex_o, e.tgt);
         end
      end
   end

   initial begin
      kind_t       k;
      logic [31:0] a;
      logic [31:0] b;
      int          drain;
      resetn = 1'b0; to_ex_v_i = 1'b0; uop_ctl_i = '0; alu_op1_i = '0; alu_op2_i = '0;
      cur_pc_d2_i = '0; rf_dst_idu_i = '0; uid_d2_i = '0;
      m = '{name:"reset", uid:0, dst:0, pc:0, res:0, tgt:0, we:0, br:0, res_known:1, tgt_known:1};

      applyStimulus(0, 1, K_ADD, 32'd9, 32'd9, 32'd0, 32'h40, 5'd7, 8'h55);
      applyStimulus(0, 1, K_JALR, 32'd9, 32'd9, 32'd8, 32'h44, 5'd7, 8'h56);
      applyStimulus(1, 1, K_ADD,  32'd5, 32'd7, 32'd0, 32'h0, 5'd3, 8'h11);
      applyStimulus(1, 1, K_SUB,  32'd3, 32'd5, 32'd0, 32'h4, 5'd4, 8'h12);
      applyStimulus(1, 1, K_SRA,  32'h8000_0000, 32'h24, 32'd0, 32'h8, 5'd5, 8'h13);
      applyStimulus(1, 1, K_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'hC, 5'd6, 8'h14);
      applyStimulus(1, 1, K_BLT,  32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd9, 8'h15);
      applyStimulus(1, 1, K_BGEU, 32'd1, 32'd2, 32'h40, 32'h104, 5'd9, 8'h16);
      applyStimulus(1, 1, K_JALR, 32'h1001, 32'd0, 32'd4, 32'h200, 5'd1, 8'h17);
      applyStimulus(1, 1, K_ADD,  32'd100, 32'd1, 32'd0, 32'h300, 5'd2, 8'h18);
      applyStimulus(1, 1, K_ADD,  32'hFFFF_FFFF, 32'd2, 32'd0, 32'h304, 5'd8, 8'h19);
      applyStimulus(1, 0, K_ADD,  32'd0, 32'd0, 32'd0, 32'h0, 5'd0, 8'h00);
      applyStimulus(1, 1, K_NONE, 32'd1, 32'd2, 32'd0, 32'h308, 5'd10, 8'h1A);
      applyStimulus(1, 1, K_ADD,  32'd4, 32'd4, 32'd0, 32'h30C, 5'd11, 8'h1B);
      applyStimulus(0, 1, K_ADD,  32'd4, 32'd4, 32'd0, 32'h310, 5'd11, 8'h1C);

      for (int i = 0; i < 400; i++) begin
         k = kind_t'($urandom_range(0, 17));
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) != 0), k, a, b,
                       $urandom, $urandom, 5'($urandom), 8'($urandom));
      end
      applyStimulus(1, 0, K_NONE, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 8'd0);

      drain = 0;
      while (sb.size() > 0 && drain < 10) begin
         @(posedge clk);
         drain++;
      end
      #2;
      if (sb.size() > 0) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/n2_exec_unit.md
Name: n2_exec_unit

Overview:
Single-cycle integer execute stage of the NanoCore RV32IM one-issue pipeline, sitting after the two-stage decode unit (d2). It takes decoded micro-op control plus resolved operands from d2. It produces a registered ALU result with a register-file write request, or a registered branch/JALR redirect with its target PC. Top level uses its outputs for register write-back, operand bypass to d1, pipeline flush and co-sim tracking by uid.

Parameters:
TWO_CYCLE_ALU, 0, accepted for interface compatibility; no functional effect; latency is always 1 cycle.
TWO_CYCLE_COMPARE, 0, accepted for interface compatibility; no functional effect.

Ports:
clk  in  1  clock.
resetn  in  1  reset, synchronous, active-low.
to_ex_v_i  in  1  d2 issues a micro-op to this unit this cycle.
uid_d2_i  in  8  unique id of the issued micro-op.
uid_ex_o  out  8  registered uid of the executed micro-op.
rf_dst_idu_i  in  5  destination register index.
rf_dst_ex_o  out  5  registered destination index.
uop_ctl_i  in  uop_ctl_t  decoded control struct from d2.
alu_op1_i  in  32  operand 1 (rs1 value or PC as chosen by d2).
alu_op2_i  in  32  operand 2 (rs2 value or immediate as chosen by d2).
alu_rst_ex_o  out  32  registered ALU result.
rf_we_ex_o  out  1  registered register-file write enable.
is_branch_ex_o  out  1  registered redirect valid (taken branch or JALR).
branch_pc_ex_o  out  32  registered redirect target.
cur_pc_d2_i  in  32  PC of the issued micro-op.
cur_pc_ex_o  out  32  registered PC.

Behaviour:
- All outputs are flops. On clk rise with resetn=0, every output is cleared to 0.
- Latency is 1 cycle. Inputs sampled while to_ex_v_i=1 appear on the outputs the next cycle.
- Cycle with to_ex_v_i=0: rf_we_ex_o and is_branch_ex_o are 0 next cycle. Data outputs hold their last values.
- Cycle with to_ex_v_i=1: uid_ex_o, rf_dst_ex_o and cur_pc_ex_o load from the corresponding inputs.
- ALU ops are selected one-hot by uop_ctl_i flags; I-type and R-type forms share a flag. Results:
  - add: op1+op2, mod 2^32.
  - sub: op1-op2.
  - sll: op1<<op2[4:0].
  - srl: logical shift right by op2[4:0].
  - sra: arithmetic shift right by op2[4:0].
  - slt: signed compare, result 32'd1 or 32'd0.
  - sltu: unsigned compare, result 32'd1 or 32'd0.
  - xor, or, and: bitwise.
- ALU op: rf_we_ex_o=1, is_branch_ex_o=0.
- Conditional branch (beq, bne, blt, bge, bltu, bgeu) compares op1 with op2, signed or unsigned as named.
  - rf_we_ex_o=0 and rf_dst_ex_o is forced to 0. Top writes cur_pc_ex+4 to rd on redirect, so rd must read as x0.
  - Taken: is_branch_ex_o=1, branch_pc_ex_o = cur_pc_d2_i + decoded_imm.
  - Not taken: is_branch_ex_o=0.
- jalr: is_branch_ex_o=1, rf_we_ex_o=0, rf_dst_ex_o = rf_dst_idu_i.
  - branch_pc_ex_o = (op1 + decoded_imm) with bit 0 cleared.
  - Link value (PC+4) is written by top, not by this unit.
- No flag set while valid (op not owned by this unit): rf_we_ex_o=0, is_branch_ex_o=0.
- This unit does not self-flush. d2 gates to_ex_v_i on redirects, and back-to-back valid micro-ops are accepted every cycle.
- Reset asserted mid-operation clears the pending result and redirect in the same edge.

Decomposition:
- NanoCore_pkg: uop_ctl_t, regfile_size, regindex_bits=5.
- Fields of uop_ctl_t used here:
  - ALU flags: is_add, is_sub, is_sll, is_slt, is_sltu, is_xor, is_srl, is_sra, is_or, is_and.
  - Branch flags: instr_beq, instr_bne, instr_blt, instr_bge, instr_bltu, instr_bgeu, instr_jalr.
  - decoded_imm[31:0].
- Optional sub-module n2_alu_comb: combinational result, branch-taken and target logic. The top of this unit holds only the output registers.

Test Plan:
- Reset: resetn=0 for 2 cycles with to_ex_v_i=1 -> all outputs 0.
- ADD: op1=5, op2=7, rd=3, uid=0x11 -> next cycle alu_rst_ex_o=12, rf_we_ex_o=1, rf_dst_ex_o=3, uid_ex_o=0x11, is_branch_ex_o=0.
- SUB and SRA:
  - SUB 3-5 -> 0xFFFFFFFE.
  - SRA 0x80000000 by op2=0x24 (uses low 5 bits) -> 0xF8000000.
  - SLTU 1 vs 0xFFFFFFFF -> 1.
- BLT: op1=-1, op2=1, pc=0x100, imm=0x20 -> is_branch_ex_o=1, branch_pc_ex_o=0x120, rf_we_ex_o=0, rf_dst_ex_o=0.
- BGEU not taken: op1=1, op2=2 -> is_branch_ex_o=0, rf_we_ex_o=0.
- JALR: op1=0x1001, imm=4, rd=1, pc=0x200 -> is_branch_ex_o=1, branch_pc_ex_o=0x1004, rf_dst_ex_o=1, cur_pc_ex_o=0x200.
- Pipelining: back-to-back ADD then idle then reset mid-stream -> results on consecutive cycles; idle gives rf_we_ex_o=0; reset edge clears outputs.
